regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file. It generalises the 32-entry, 64-bit register-select path of the datapath into one block: storage array, N registered read ports, one write port, and a hardwired zero register (XZR). It also contains a sequenced bulk-clear engine that the pipeline controller uses on context flush. It sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 64, width of each register in bits
DEPTH, 32, number of registers (≥2; need not be a power of two)
N_READ, 2, number of independent read ports (1..4)
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
ZERO_REG, DEPTH-1, index that always reads 0 and ignores writes; a value ≥ DEPTH disables it

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write request this cycle
wr_addr  input  ADDR_W  write index
wr_data  input  DATA_W  write data
rd_en  input  N_READ  per-port read request
rd_addr  input  N_READ*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
rd_data  output  N_READ*DATA_W  port i data at [i*DATA_W +: DATA_W], registered
rd_valid  output  N_READ  port i data updated this cycle
clr_req  input  1  pulse: start bulk clear
busy  output  1  clear sequence in progress

Behaviour:
- Reset (synchronous, active-high; sampled on the clk edge):
  - All array entries = 0.
  - rd_data = 0, rd_valid = 0, busy = 0, FSM = IDLE, clear counter = 0.
  - Reset overrides every other input in the same cycle.
  - Reset asserted mid-clear aborts the clear. The array is zeroed anyway.
- Write:
  - When wr_en=1, FSM=IDLE, wr_addr<DEPTH and wr_addr≠ZERO_REG, array[wr_addr] ← wr_data at the edge.
  - Otherwise the write is silently dropped.
- Read:
  - Latency is 1 cycle.
  - When rd_en[i]=1 at edge k, rd_data[i] shows the entry value at edge k+1 and rd_valid[i]=1 for that cycle.
  - When rd_en[i]=0, rd_data[i] holds its last value and rd_valid[i]=0.
  - Reading ZERO_REG or any address ≥ DEPTH returns 0.
  - Ports are fully independent. Two ports may read the same address.
- Read/write collision (same cycle, same address, write accepted): behaviour is set by the optional feature below.
- Clear FSM:
  - IDLE: clr_req=1 → CLEAR, counter=0, busy=1 from the next cycle.
  - CLEAR: array[counter] ← 0 and counter++ each cycle. When counter=DEPTH-1 that entry is zeroed, the FSM returns to IDLE, and busy=0 on the following cycle. A clear therefore takes exactly DEPTH cycles of busy=1.
  - clr_req during CLEAR is ignored (no restart).
  - wr_en during CLEAR is dropped; the caller must stall on busy.
  - Reads during CLEAR are allowed and return current contents: cleared entries read 0, uncleared entries read their old value.
  - clr_req and wr_en in the same IDLE cycle: the write is accepted, then the clear begins and erases it.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read and an accepted write to the same address at the same edge forward wr_data, so rd_data = new value next cycle. ZERO_REG and out-of-range addresses still read 0.
- Undefined: the read returns the pre-write (old) value; the new value is visible to reads issued from the next cycle on.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum (RF_IDLE, RF_CLEAR)
  - default DATA_W/DEPTH constants
  - XZR index constant (31)
- One natural sub-module, regfile_rd_port: a single registered read port with zero/out-of-range masking and the bypass compare. It is instantiated N_READ times with a generate loop.

Test Plan:
- After reset: write 0xDEAD_BEEF_0000_0001 to r5, then read r5 on port 0 the next cycle → rd_data[0]=0xDEAD_BEEF_0000_0001, with rd_valid[0]=1 exactly one cycle after rd_en.
- Write 0xFFFF_FFFF_FFFF_FFFF to r31 (ZERO_REG), then read r31 on both ports → both return 0. Read r3 and r3 on ports 0 and 1 at the same time → identical data.
- r7=0x11. In the same cycle write r7=0x22 and read r7:
  - with REGFILE_BYPASS_EN → 0x22
  - without → 0x11
  - either way, the next read → 0x22
- Fill r0..r30 with their index+1, pulse clr_req:
  - busy is high for exactly 32 cycles.
  - A read of r20 at clear cycle 5 → 21; at clear cycle 25 → 0.
  - A wr_en to r2 during the clear → dropped.
  - After busy falls, all entries read 0.
- clr_req again at clear cycle 10 → no restart; busy still falls at cycle 32.
- Assert reset at clear cycle 12 → busy=0, FSM idle, all rd_data=0 next cycle. A read of r30 → 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the multi-port register file.
//   - rf_state_t : bulk-clear sequencer state (RF_IDLE, RF_CLEAR)
//   - RF_DATA_W / RF_DEPTH : default register width and count
//   - RF_XZR : architectural zero-register index for the default depth
//   - rf_live() : true when an index names real, writable storage
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 64;
  localparam int RF_DEPTH  = 32;
  localparam int RF_XZR    = 31;

  // An index is "live" when it addresses an existing entry that is not the
  // hardwired zero register. A zero_reg value >= depth never matches, which
  // is how the zero register is disabled.
  function automatic logic rf_live(input int idx, input int depth, input int zero_reg);
    return (idx < depth) && (idx != zero_reg);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
//   One registered read port of regfile_mp. Masks the zero register and
//   out-of-range addresses to 0 and, when REGFILE_BYPASS_EN is defined,
//   forwards a same-edge accepted write to the same address.
//
//   Build option: REGFILE_BYPASS_EN (defined -> write-to-read forwarding,
//   undefined -> a colliding read returns the pre-write value).
//
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     rd_en       : read request this cycle
//     rd_addr     : read index
//     arr_word    : storage word at rd_addr (0 when rd_addr is out of range)
//     wr_accept   : write port commits this edge        (bypass build only)
//     wr_addr     : write index                         (bypass build only)
//     wr_data     : write data                          (bypass build only)
//     rd_data     : registered read data, holds when rd_en=0
//     rd_valid    : rd_data was updated by the previous edge
// -----------------------------------------------------------------------------
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_word,
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_accept,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  always_comb begin
    rd_next = rf_live(int'(rd_addr), DEPTH, ZERO_REG) ? arr_word : '0;
`ifdef REGFILE_BYPASS_EN
    // wr_accept already excludes the zero register and out-of-range indices,
    // so forwarding can never leak a value into a read-as-zero slot.
    if (wr_accept && (wr_addr == rd_addr)) begin
      rd_next = wr_data;
    end
`endif
  end

  // ---- stage p1: registered read result ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        rd_data_p1 <= rd_next;
      end
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised register file: DEPTH x DATA_W storage, one write port,
//   N_READ independent registered read ports (1-cycle latency), a hardwired
//   zero register, and a sequenced bulk-clear engine used on context flush.
//
//   Build option: REGFILE_BYPASS_EN -- when defined, a read and an accepted
//   write to the same address on the same edge return the new data;
//   otherwise the read returns the old data.
//
//   Ports:
//     clk       : clock, all state updates on the rising edge
//     reset     : synchronous active-high reset (zeroes array and outputs)
//     wr_en     : write request
//     wr_addr   : write index
//     wr_data   : write data
//     rd_en     : per-port read request            [N_READ]
//     rd_addr   : port i address at [i*ADDR_W +: ADDR_W]
//     rd_data   : port i data at [i*DATA_W +: DATA_W], registered
//     rd_valid  : per-port "data updated this cycle" [N_READ]
//     clr_req   : pulse to start a bulk clear
//     busy      : bulk clear in progress (exactly DEPTH cycles)
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int N_READ   = 2,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [N_READ-1:0]          rd_en,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data,
  output logic [N_READ-1:0]          rd_valid,
  input  logic                       clr_req,
  output logic                       busy
);

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;
  logic              wr_accept;
  logic [DATA_W-1:0] mem [DEPTH];

  assign clr_last  = (int'(clr_cnt) == DEPTH - 1);

  // Writes are refused while clearing; the caller stalls on busy instead.
  assign wr_accept = wr_en && (state == RF_IDLE) &&
                     rf_live(int'(wr_addr), DEPTH, ZERO_REG);

  // ---- clear sequencer: state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RF_CLEAR && !clr_last) begin
        clr_cnt <= clr_cnt + 1'b1;
      end else begin
        clr_cnt <= '0;
      end
    end
  end

  // ---- clear sequencer: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      RF_IDLE:  if (clr_req)  state_nxt = RF_CLEAR;
      RF_CLEAR: if (clr_last) state_nxt = RF_IDLE;
      default:  state_nxt = RF_IDLE;
    endcase
  end

  // ---- clear sequencer: outputs ----
  always_comb begin
    busy = (state == RF_CLEAR);
  end

  // ---- storage array ----
  // A write in the same IDLE cycle as clr_req lands first; the sweep that
  // starts on the next cycle erases it along with everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_accept) begin
        mem[wr_addr] <= wr_data;
      end
      if (state == RF_CLEAR) begin
        mem[clr_cnt] <= '0;
      end
    end
  end

  // ---- read ports ----
  for (genvar g = 0; g < N_READ; g++) begin : g_rd
    logic [ADDR_W-1:0] addr_g;
    logic [DATA_W-1:0] word_g;

    assign addr_g = rd_addr[g*ADDR_W +: ADDR_W];
    // Guard the array index so non-power-of-two depths never read past the end.
    assign word_g = (int'(addr_g) < DEPTH) ? mem[addr_g] : '0;

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en[g]),
      .rd_addr   (addr_g),
      .arr_word  (word_g),
`ifdef REGFILE_BYPASS_EN
      .wr_accept (wr_accept),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
`endif
      .rd_data   (rd_data[g*DATA_W +: DATA_W]),
      .rd_valid  (rd_valid[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed self-checking bench for regfile_mp (default parameters:
//   DATA_W=64, DEPTH=32, N_READ=2, ZERO_REG=31).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_valid;
  logic         clr_req;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .clr_req  (clr_req),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read2(input int a0, input int a1);
    rd_en   = 2'b11;
    rd_addr = {5'(a1), 5'(a0)};
    tick();
    rd_en   = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if (rd_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h need 0", rd_data);
    end
    n_tests++;
    if (rd_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rd_valid: got %b need 00", rd_valid);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b need 0", busy);
    end
  endtask

  task automatic test_write_read();
    do_write(5, 64'hDEAD_BEEF_0000_0001);
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd5};
    n_tests++;
    if (rd_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_rd_valid_before: got %b need 00", rd_valid);
    end
    tick();
    rd_en = 2'b00;
    n_tests++;
    if (rd_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL wr_rd_data: got %h need deadbeef00000001", rd_data[63:0]);
    end
    n_tests++;
    if (rd_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_rd_valid: got %b need 01", rd_valid);
    end
    tick();
    n_tests++;
    if (rd_valid !== 2'b00 || rd_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL wr_rd_hold: got valid %b data %h need 00 deadbeef00000001",
               rd_valid, rd_data[63:0]);
    end
  endtask

  task automatic test_zero_reg_and_shared();
    do_write(31, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read2(31, 31);
    n_tests++;
    if (rd_data !== 128'h0 || rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL zero_reg_read: got valid %b data %h need 11 0", rd_valid, rd_data);
    end
    do_write(3, 64'h0123_4567_89AB_CDEF);
    do_read2(3, 3);
    n_tests++;
    if (rd_data !== {64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF}) begin
      n_fail++;
      $display("FAIL shared_read_r3: got %h need both 0123456789abcdef", rd_data);
    end
    do_read2(5, 3);
    n_tests++;
    if (rd_data !== {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001}) begin
      n_fail++;
      $display("FAIL indep_ports: got %h need 0123456789abcdef/deadbeef00000001", rd_data);
    end
  endtask

  task automatic test_collision();
    logic [63:0] exp_col;
`ifdef REGFILE_BYPASS_EN
    exp_col = 64'h22;
`else
    exp_col = 64'h11;
`endif
    do_write(7, 64'h11);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 64'h22;
    rd_en   = 2'b11;
    rd_addr = {5'd3, 5'd7};
    tick();
    wr_en = 1'b0;
    rd_en = 2'b00;
    n_tests++;
    if (rd_data[63:0] !== exp_col) begin
      n_fail++;
      $display("FAIL collision_read: got %h need %h", rd_data[63:0], exp_col);
    end
    n_tests++;
    if (rd_data[127:64] !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL collision_other_port: got %h need 0123456789abcdef", rd_data[127:64]);
    end
    do_read2(7, 7);
    n_tests++;
    if (rd_data !== {64'h22, 64'h22}) begin
      n_fail++;
      $display("FAIL collision_after: got %h need both 22", rd_data);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < 31; i++) do_write(i, 64'(i + 1));
    do_read2(20, 30);
    n_tests++;
    if (rd_data !== {64'd31, 64'd21}) begin
      n_fail++;
      $display("FAIL fill_check: got %h need 31/21", rd_data);
    end
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 60 && busy; c++) begin
      busy_cnt++;
      rd_en = 2'b00;
      wr_en = 1'b0;
      if (c == 5 || c == 25) begin
        rd_en   = 2'b01;
        rd_addr = {5'd0, 5'd20};
      end
      if (c == 10) begin
        wr_en   = 1'b1;
        wr_addr = 5'd2;
        wr_data = 64'h99;
      end
      tick();
      if (c == 5) begin
        n_tests++;
        if (rd_data[63:0] !== 64'd21 || rd_valid !== 2'b01) begin
          n_fail++;
          $display("FAIL clear_c5_r20: got valid %b data %h need 01 15", rd_valid, rd_data[63:0]);
        end
      end
      if (c == 25) begin
        n_tests++;
        if (rd_data[63:0] !== 64'd0) begin
          n_fail++;
          $display("FAIL clear_c25_r20: got %h need 0", rd_data[63:0]);
        end
      end
    end
    rd_en = 2'b00;
    wr_en = 1'b0;
    n_tests++;
    if (busy_cnt !== 32) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d need 32", busy_cnt);
    end
    for (int i = 0; i < 32; i += 2) begin
      do_read2(i, i + 1);
      n_tests++;
      if (rd_data !== 128'h0) begin
        n_fail++;
        $display("FAIL clear_zero_r%0d_r%0d: got %h need 0", i, i + 1, rd_data);
      end
    end
  endtask

  task automatic test_clear_no_restart();
    int busy_cnt;
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 80 && busy; c++) begin
      busy_cnt++;
      clr_req = (c == 10);
      tick();
    end
    clr_req = 1'b0;
    n_tests++;
    if (busy_cnt !== 32) begin
      n_fail++;
      $display("FAIL no_restart_busy_len: got %0d need 32", busy_cnt);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_restart_idle: got busy %b need 0", busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_write(30, 64'h30);
    do_write(0, 64'h5);
    do_read2(30, 0);
    n_tests++;
    if (rd_data !== {64'h5, 64'h30}) begin
      n_fail++;
      $display("FAIL pre_abort_read: got %h need 5/30", rd_data);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || rd_data !== 128'h0 || rd_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_state: got busy %b valid %b data %h need 0 00 0",
               busy, rd_valid, rd_data);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: got busy %b need 0", busy);
    end
    do_read2(30, 30);
    n_tests++;
    if (rd_data !== 128'h0) begin
      n_fail++;
      $display("FAIL abort_r30: got %h need 0", rd_data);
    end
    do_write(4, 64'h44);
    do_read2(4, 30);
    n_tests++;
    if (rd_data !== {64'h0, 64'h44}) begin
      n_fail++;
      $display("FAIL abort_write_after: got %h need 0/44", rd_data);
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    clr_req = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg_and_shared();
    test_collision();
    test_clear();
    test_clear_no_restart();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
